// File: rtl/regfile_sequencer.sv
//------------------------------------------------------------------------------
// regfile_sequencer
//
// Sequences one register-file operation per request: read two source
// registers plus R15, capture the pre-write values, optionally perform a
// single write cycle (general register and/or R15), then present the captured
// operands as a response held until the consumer takes it.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (accepted only in IDLE)
//   req_rs1, req_rs2         source register indices
//   req_rd, req_wr,
//   req_wdata                destination index, write enable, write data
//   req_r15_wr,
//   req_r15_wdata            R15 write enable and data
//   rsp_valid / rsp_ready    response handshake
//   rsp_op1, rsp_op2,
//   rsp_r15                  captured pre-write operand values
//   rf_rwe                   register-file mode: 1 = read, 0 = write
//   rf_reg1, rf_reg2         register-file read indices
//   rf_wreg, rf_wdata,
//   rf_wdata15               register-file write index/data and R15 data
//   rf_rdata1, rf_rdata2,
//   rf_rdata15               register-file read data (one cycle after read)
//   txn_count                completed-transaction counter (wraps)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module regfile_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_rs1,
    input  logic [3:0]  req_rs2,
    input  logic [3:0]  req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_wdata,
    input  logic        req_r15_wr,
    input  logic [15:0] req_r15_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_op1,
    output logic [15:0] rsp_op2,
    output logic [15:0] rsp_r15,
    output logic        rf_rwe,
    output logic [3:0]  rf_reg1,
    output logic [3:0]  rf_reg2,
    output logic [3:0]  rf_wreg,
    output logic [15:0] rf_wdata,
    output logic [15:0] rf_wdata15,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    input  logic [15:0] rf_rdata15,
    output logic [7:0]  txn_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // Latched request fields (source indices live directly in rf_reg1/rf_reg2)
    logic [3:0]  rd_reg;
    logic        wr_reg;
    logic [15:0] wdata_reg;
    logic        r15_wr_reg;
    logic [15:0] r15_wdata_reg;

    // Write values prepared while the read data is on the bus
    logic [15:0] wdata15_next;
    logic [15:0] wdata_next;
    logic [3:0]  wreg_next;
    logic        do_write;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next state and state-decoded outputs. rf_rwe is decoded from the state
    // so that an asynchronous reset during WRITE drops back to read mode
    // immediately.
    //--------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rf_rwe     = 1'b1;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = do_write ? WRITE : RESP;
            end
            WRITE: begin
                rf_rwe     = 1'b0;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign do_write = wr_reg | r15_wr_reg;

    // R15 is always rewritten during WRITE: either with new data or with the
    // value just read, so it is never disturbed unintentionally. With no
    // general write the write port targets R15 too, carrying the same data.
    // When rd is R15 the dedicated R15 data wins.
    always_comb begin
        wdata15_next = r15_wr_reg ? r15_wdata_reg : rf_rdata15;
        if (wr_reg && (rd_reg != 4'd15)) begin
            wreg_next  = rd_reg;
            wdata_next = wdata_reg;
        end else begin
            wreg_next  = 4'd15;
            wdata_next = wdata15_next;
        end
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_reg1       <= 4'd0;
            rf_reg2       <= 4'd0;
            rd_reg        <= 4'd0;
            wr_reg        <= 1'b0;
            wdata_reg     <= 16'h0000;
            r15_wr_reg    <= 1'b0;
            r15_wdata_reg <= 16'h0000;
            rsp_op1       <= 16'h0000;
            rsp_op2       <= 16'h0000;
            rsp_r15       <= 16'h0000;
            rf_wreg       <= 4'd0;
            rf_wdata      <= 16'h0000;
            rf_wdata15    <= 16'h0000;
            txn_count     <= 8'h00;
        end else begin
            if ((state_reg == IDLE) && req_valid) begin
                rf_reg1       <= req_rs1;
                rf_reg2       <= req_rs2;
                rd_reg        <= req_rd;
                wr_reg        <= req_wr;
                wdata_reg     <= req_wdata;
                r15_wr_reg    <= req_r15_wr;
                r15_wdata_reg <= req_r15_wdata;
            end
            if (state_reg == CAPTURE) begin
                rsp_op1 <= rf_rdata1;
                rsp_op2 <= rf_rdata2;
                rsp_r15 <= rf_rdata15;
                // Write outputs only change when a write is about to happen
                if (do_write) begin
                    rf_wreg    <= wreg_next;
                    rf_wdata   <= wdata_next;
                    rf_wdata15 <= wdata15_next;
                end
            end
            if ((state_reg == RESP) && rsp_ready) begin
                txn_count <= txn_count + 8'd1;
            end
        end
    end

endmodule
